// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - frames one multi-word sensor sample into a checksummed UART byte stream
//
// Ports:
//   clk_in        system clock
//   n_rst         asynchronous active-low reset
//   sample_valid  one-cycle strobe, sample_data valid
//   sample_data   NUM_WORDS x 16-bit words, word k in [16k+15:16k]
//   sample_ready  high when a sample will be accepted
//   tx_ready      transmitter ready_out
//   tx_en         one-cycle pulse to transmitter uart_en
//   tx_data       byte presented to transmitter data_in
//   busy          frame in progress
//   seq_out       sequence number of the last started frame
//   drop_cnt      saturating count of samples dropped while busy
module uart_frame_packer #(
  parameter int         NUM_WORDS = 7,
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         WORD_BITS = 16
) (
  input  logic                           clk_in,
  input  logic                           n_rst,
  input  logic                           sample_valid,
  input  logic [NUM_WORDS*WORD_BITS-1:0] sample_data,
  output logic                           sample_ready,
  input  logic                           tx_ready,
  output logic                           tx_en,
  output logic [7:0]                     tx_data,
  output logic                           busy,
  output logic [7:0]                     seq_out,
  output logic [7:0]                     drop_cnt
);

  localparam int NUM_BYTES = 3 + 2 * NUM_WORDS;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT
  } state_t;

  state_t                         state_q, state_d;
  logic [NUM_WORDS*WORD_BITS-1:0] shadow_q, shadow_d;
  logic [7:0]                     seq_cnt_q, seq_cnt_d;
  logic [7:0]                     seq_q, seq_d;
  logic [7:0]                     chk_q, chk_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [7:0]                     tx_data_q, tx_data_d;
  logic [7:0]                     drop_q, drop_d;

  logic [IDX_W-1:0]               nxt_idx;
  logic [7:0]                     nxt_byte;
  logic                           nxt_is_data;

  // Byte at frame position idx: header, sequence, data words MSB-first, checksum.
  function automatic logic [7:0] byte_at(
    input logic [IDX_W-1:0]               idx,
    input logic [7:0]                     seq,
    input logic [7:0]                     chk,
    input logic [NUM_WORDS*WORD_BITS-1:0] shadow
  );
    logic [7:0]           b;
    logic [WORD_BITS-1:0] word;
    int                   di;
    b    = 8'h00;
    word = '0;
    di   = int'(idx) - 2;
    if (idx == '0) begin
      b = HEADER;
    end else if (idx == IDX_W'(1)) begin
      b = seq;
    end else if (idx == LAST_IDX) begin
      b = chk;
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (k == di / 2) begin
          word = shadow[k*WORD_BITS +: WORD_BITS];
        end
      end
      b = di[0] ? word[7:0] : word[15:8];
    end
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    seq_cnt_d = seq_cnt_q;
    seq_d     = seq_q;
    chk_d     = chk_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    drop_d    = drop_q;

    nxt_idx     = idx_q + IDX_W'(1);
    nxt_byte    = byte_at(nxt_idx, seq_q, chk_q, shadow_q);
    // Only data bytes feed the checksum; SEQ is preloaded and CHK is the sum itself.
    nxt_is_data = (nxt_idx >= IDX_W'(2)) && (nxt_idx < LAST_IDX);

    case (state_q)
      S_IDLE: begin
        if (sample_valid && tx_ready) begin
          shadow_d  = sample_data;
          seq_d     = seq_cnt_q;
          seq_cnt_d = seq_cnt_q + 8'd1;
          chk_d     = seq_cnt_q;
          idx_d     = '0;
          // tx_data is loaded on entry to ISSUE so it is stable while tx_en is high.
          tx_data_d = HEADER;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Transmitter holds ready one cycle past acceptance; wait for it to drop.
        if (!tx_ready) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_ready) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          idx_d     = nxt_idx;
          tx_data_d = nxt_byte;
          if (nxt_is_data) begin
            chk_d = chk_q + nxt_byte;
          end
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sample_valid && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      seq_cnt_q <= 8'h00;
      seq_q     <= 8'h00;
      chk_q     <= 8'h00;
      idx_q     <= '0;
      tx_data_q <= 8'h00;
      drop_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      seq_cnt_q <= seq_cnt_d;
      seq_q     <= seq_d;
      chk_q     <= chk_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign tx_en    = (state_q == S_ISSUE);
  assign tx_data  = tx_data_q;
  assign seq_out  = seq_q;
  assign drop_cnt = drop_q;
  // Gated by n_rst so no upstream handshake can complete while reset is held.
  assign sample_ready = (state_q == S_IDLE) && tx_ready && n_rst;

endmodule

// File: tb/tb_uart_frame_packer.sv
// tb/tb_uart_frame_packer.sv - directed self-checking bench for uart_frame_packer
module tb_uart_frame_packer;

  logic        clk_in = 1'b0;
  logic        n_rst;

  // NUM_WORDS=1 instance
  logic        sample_valid1;
  logic [15:0] sample_data1;
  logic        sample_ready1, tx_ready1, tx_en1, busy1;
  logic [7:0]  tx_data1, seq_out1, drop_cnt1;

  // NUM_WORDS=7 instance
  logic         sample_valid7;
  logic [111:0] sample_data7;
  logic         sample_ready7, tx_ready7, tx_en7, busy7;
  logic [7:0]   tx_data7, seq_out7, drop_cnt7;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_in = ~clk_in;

  uart_frame_packer #(.NUM_WORDS(1)) u_dut1 (
    .clk_in(clk_in), .n_rst(n_rst),
    .sample_valid(sample_valid1), .sample_data(sample_data1), .sample_ready(sample_ready1),
    .tx_ready(tx_ready1), .tx_en(tx_en1), .tx_data(tx_data1),
    .busy(busy1), .seq_out(seq_out1), .drop_cnt(drop_cnt1)
  );

  uart_frame_packer u_dut7 (
    .clk_in(clk_in), .n_rst(n_rst),
    .sample_valid(sample_valid7), .sample_data(sample_data7), .sample_ready(sample_ready7),
    .tx_ready(tx_ready7), .tx_en(tx_en7), .tx_data(tx_data7),
    .busy(busy7), .seq_out(seq_out7), .drop_cnt(drop_cnt7)
  );

  // Transmitter models: accept on tx_en, ready stays high one cycle, then low 4 cycles.
  int          tmr1 = 0, tmr7 = 0;
  logic        prev1 = 1'b0, prev7 = 1'b0;
  int          dbl1 = 0, dbl7 = 0;
  logic [7:0]  bytes1[$];
  logic [7:0]  bytes7[$];

  assign tx_ready1 = (tmr1 == 0) || (tmr1 == 5);
  assign tx_ready7 = (tmr7 == 0) || (tmr7 == 5);

  always @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      tmr1  <= 0;
      prev1 <= 1'b0;
    end else begin
      if (tx_en1) begin
        bytes1.push_back(tx_data1);
        tmr1 <= 5;
      end else if (tmr1 > 0) begin
        tmr1 <= tmr1 - 1;
      end
      if (tx_en1 && prev1) dbl1 <= dbl1 + 1;
      prev1 <= tx_en1;
    end
  end

  always @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      tmr7  <= 0;
      prev7 <= 1'b0;
    end else begin
      if (tx_en7) begin
        bytes7.push_back(tx_data7);
        tmr7 <= 5;
      end else if (tmr7 > 0) begin
        tmr7 <= tmr7 - 1;
      end
      if (tx_en7 && prev7) dbl7 <= dbl7 + 1;
      prev7 <= tx_en7;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    end
  endtask

  task automatic send1(input logic [15:0] data);
    for (int i = 0; i < 200 && !sample_ready1; i++) @(negedge clk_in);
    check_eq("ready1", 32'(sample_ready1), 32'd1);
    sample_data1  = data;
    sample_valid1 = 1'b1;
    @(negedge clk_in);
    sample_valid1 = 1'b0;
  endtask

  task automatic send7(input logic [111:0] data);
    for (int i = 0; i < 400 && !sample_ready7; i++) @(negedge clk_in);
    check_eq("ready7", 32'(sample_ready7), 32'd1);
    sample_data7  = data;
    sample_valid7 = 1'b1;
    @(negedge clk_in);
    sample_valid7 = 1'b0;
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 2000 && busy1; i++) @(negedge clk_in);
    check_eq("idle1", 32'(busy1), 32'd0);
  endtask

  task automatic wait_idle7();
    for (int i = 0; i < 4000 && busy7; i++) @(negedge clk_in);
    check_eq("idle7", 32'(busy7), 32'd0);
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] s;

  initial begin
    n_rst         = 1'b0;
    sample_valid1 = 1'b0;
    sample_data1  = '0;
    sample_valid7 = 1'b0;
    sample_data7  = '0;
    repeat (3) @(negedge clk_in);

    // Reset values
    check_eq("rst_tx_en", 32'(tx_en1), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data1), 32'h00);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_ready", 32'(sample_ready1), 32'd0);
    check_eq("rst_seq", 32'(seq_out1), 32'h00);
    check_eq("rst_drop", 32'(drop_cnt1), 32'h00);
    n_rst = 1'b1;
    @(negedge clk_in);
    check_eq("idle_ready", 32'(sample_ready1), 32'd1);

    // Frame 1: 0x1234, one-cycle latency to tx_en
    bytes1.delete();
    send1(16'h1234);
    check_eq("lat_tx_en", 32'(tx_en1), 32'd1);
    check_eq("lat_tx_data", 32'(tx_data1), 32'hA5);
    check_eq("busy_mid", 32'(busy1), 32'd1);
    wait_idle1();
    exp_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h46};
    check_frame("f1", bytes1, exp_q);
    check_eq("f1_seq", 32'(seq_out1), 32'h00);
    check_eq("f1_tx_hold", 32'(tx_data1), 32'h46);

    // Frame 2: 0xFFFF
    bytes1.delete();
    send1(16'hFFFF);
    wait_idle1();
    exp_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF};
    check_frame("f2", bytes1, exp_q);
    check_eq("f2_seq", 32'(seq_out1), 32'h01);

    // 256 frames: sequence wraps FF -> 00, checksum = SEQ + 0x46
    for (int i = 0; i < 256; i++) begin
      s = 8'(2 + i);
      bytes1.delete();
      send1(16'h1234);
      wait_idle1();
      check_eq("wrap_len", 32'(bytes1.size()), 32'd5);
      if (bytes1.size() == 5) begin
        check_eq("wrap_seq", 32'(bytes1[1]), 32'(s));
        check_eq("wrap_chk", 32'(bytes1[4]), 32'(8'(s + 8'h46)));
      end
    end
    check_eq("wrap_seq_out", 32'(seq_out1), 32'h01);
    check_eq("dbl1", 32'(dbl1), 32'd0);

    // NUM_WORDS=7, all 0x0101: 17 single-cycle pulses, CHK = 0x0E
    bytes7.delete();
    send7({7{16'h0101}});
    wait_idle7();
    exp_q = '{8'hA5, 8'h00};
    for (int i = 0; i < 14; i++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h0E);
    check_frame("f7", bytes7, exp_q);
    check_eq("dbl7", 32'(dbl7), 32'd0);

    // Three drops mid-frame with different data; frame must be unchanged
    bytes7.delete();
    send7({7{16'h0101}});
    repeat (10) @(negedge clk_in);
    for (int i = 0; i < 3; i++) begin
      sample_data7  = {7{16'hFFFF}};
      sample_valid7 = 1'b1;
      @(negedge clk_in);
      sample_valid7 = 1'b0;
      @(negedge clk_in);
    end
    check_eq("drop3_busy", 32'(busy7), 32'd1);
    wait_idle7();
    check_eq("drop3", 32'(drop_cnt7), 32'd3);
    exp_q = '{8'hA5, 8'h01};
    for (int i = 0; i < 14; i++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h0F);
    check_frame("fd", bytes7, exp_q);

    // Saturation: sample_valid held high across several frames
    sample_data7  = {7{16'h0101}};
    sample_valid7 = 1'b1;
    repeat (600) @(negedge clk_in);
    sample_valid7 = 1'b0;
    check_eq("drop_sat", 32'(drop_cnt7), 32'hFF);
    wait_idle7();
    check_eq("drop_sat_hold", 32'(drop_cnt7), 32'hFF);

    // Reset after byte 3 of a frame
    bytes1.delete();
    send1(16'h1234);
    for (int i = 0; i < 200 && bytes1.size() < 3; i++) @(negedge clk_in);
    check_eq("pre_rst_bytes", 32'(bytes1.size()), 32'd3);
    n_rst = 1'b0;
    @(negedge clk_in);
    check_eq("mr_tx_en", 32'(tx_en1), 32'd0);
    check_eq("mr_busy", 32'(busy1), 32'd0);
    check_eq("mr_seq", 32'(seq_out1), 32'h00);
    check_eq("mr_tx_data", 32'(tx_data1), 32'h00);
    @(negedge clk_in);
    n_rst = 1'b1;
    repeat (20) @(negedge clk_in);
    check_eq("mr_no_more", 32'(bytes1.size()), 32'd3);
    bytes1.delete();
    send1(16'h1234);
    wait_idle1();
    exp_q = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h46};
    check_frame("fr", bytes1, exp_q);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_packer.md
Name: uart_frame_packer

Overview:
- Upstream feeder for the byte-wide UART transmitter in the MPU6050 path.
- Captures one multi-word sensor sample (accel X/Y/Z, temp, gyro X/Y/Z) from the I2C reader.
- Serialises the sample into a framed byte stream: header, sequence number, data bytes MSB-first, checksum.
- Drives the transmitter one byte at a time through its uart_en/ready_out handshake.

Parameters:
- NUM_WORDS, 7, number of 16-bit words per sample (1..15).
- HEADER, 8'hA5, first byte of every frame.
- WORD_BITS, 16, width of each sample word; fixed, splits into exactly 2 bytes.

Ports:
- clk_in  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- sample_valid  input  1  one-cycle strobe: sample_data is valid.
- sample_data  input  NUM_WORDS*16  word 0 in bits [15:0], word k in [16k+15:16k].
- sample_ready  output  1  high when a sample will be accepted.
- tx_ready  input  1  transmitter ready_out.
- tx_en  output  1  one-cycle pulse to the transmitter uart_en.
- tx_data  output  8  byte presented to the transmitter data_in.
- busy  output  1  frame in progress.
- seq_out  output  8  sequence number of the last started frame.
- drop_cnt  output  8  saturating count of samples dropped while busy.

Behaviour:
- Reset values (asynchronous, n_rst low): state IDLE, tx_en 0, tx_data 8'h00, busy 0, sample_ready 0, seq_out 8'h00, drop_cnt 0, checksum 0, byte index 0, internal sequence counter 0.
- Frame length is 3 + 2*NUM_WORDS bytes, sent in this order:
  - HEADER.
  - SEQ.
  - For word 0 up to word NUM_WORDS-1: high byte, then low byte.
  - CHK = 8-bit modulo-256 sum of SEQ and all data bytes. HEADER is excluded.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT.
- IDLE:
  - busy=0. sample_ready=1 only when tx_ready=1.
  - On sample_valid && sample_ready: latch sample_data into a shadow register, SEQ = sequence counter, checksum = SEQ, byte index = 0, seq_out = SEQ, sequence counter increments (wraps 8'hFF -> 8'h00). Go to ISSUE.
  - sample_valid while tx_ready=0 in IDLE is ignored and not counted as a drop.
- ISSUE:
  - tx_data = current byte. tx_en=1 for exactly this one cycle. Go to WAIT_ACK.
  - tx_data holds its value until the next ISSUE.
- WAIT_ACK:
  - The transmitter keeps ready high for one cycle after accepting. Stay here until tx_ready=0, then go to WAIT_DONE.
  - No timeout.
- WAIT_DONE: stay until tx_ready=1, then go to NEXT.
- NEXT:
  - If the byte just sent was CHK, return to IDLE.
  - Otherwise: index+1; add the next byte to the checksum (CHK itself is never added); go to ISSUE.
- Inter-byte gap: ISSUE occurs 2 cycles after tx_ready rises (WAIT_DONE -> NEXT -> ISSUE). Latency from accepted sample_valid to the first tx_en is 1 cycle.
- busy=1 in every state except IDLE. sample_ready=0 whenever busy.
- Dropped samples: sample_valid while busy drops the sample. drop_cnt increments and saturates at 8'hFF. The shadow register is never overwritten mid-frame.
- Simultaneous events: sample_valid on the cycle of the IDLE return from NEXT is a drop, because busy is still 1 that cycle.
- Byte selection: index 0 = HEADER, 1 = SEQ, 2..2*NUM_WORDS+1 = data, last = CHK. Data byte at index i uses word (i-2)/2; an even (i-2) selects the high byte.
- Reset mid-frame: abort immediately. Outputs take reset values, no remaining bytes are sent, and the sequence restarts at 0.

Test Plan:
- NUM_WORDS=1, word 0x1234, behavioural transmitter model -> tx_data sequence A5,00,12,34,46; seq_out=00; busy falls after the CHK handshake.
- Second frame with word 0xFFFF -> bytes A5,01,FF,FF,FF (01+FF+FF mod 256 = FF).
- Default NUM_WORDS=7, all words 0x0101 -> 17 bytes. tx_en pulses exactly 17 times, each 1 cycle wide. CHK = SEQ+14 mod 256.
- Three sample_valid strobes mid-frame -> drop_cnt=3 and the frame data is unchanged. 260 strobes -> drop_cnt saturates at FF.
- Send 256 frames -> SEQ wraps FF -> 00 and the checksum stays correct.
- Assert n_rst low after byte 3 of a frame -> tx_en stays 0, busy=0, seq_out=00. The next frame starts with A5,00.
